// File: rtl/drum_pkg.sv
// Shared helpers and default-configuration types for the DRUM approximate multiplier.
package drum_pkg;

  localparam int unsigned MAX_W     = 64;
  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_K     = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  typedef logic [clog2(2 * DEF_WIDTH)-1:0] SHW_T;
  typedef logic [DEF_K-1:0]                MANT_T;

  // Position of the most significant set bit; 0 for an all-zero input.
  function automatic int unsigned lod_idx(input logic [MAX_W-1:0] x);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (x[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/drum_operand_prep.sv
// Per-operand DRUM preparation: magnitude, leading-one detect, K-bit unbiased
// mantissa and truncation shift.
module drum_operand_prep
  import drum_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned K      = 4,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned SHW    = clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [K-1:0]     m_o,
  output logic [SHW-1:0]   sh_o,
  output logic             sgn_o
);

  logic [WIDTH-1:0] ux;
  int unsigned      k;

  always_comb begin
    sgn_o = 1'b0;
    ux    = x_i;
    k     = 0;
    m_o   = '0;
    sh_o  = '0;
    if (SIGNED && x_i[WIDTH-1]) begin
      sgn_o = 1'b1;
      ux    = -x_i;
    end
    k = lod_idx(MAX_W'(ux));
    // Large operands keep the K bits under the leading one with the LSB forced to 1.
    if (k >= K) begin
      sh_o = SHW'(k - (K - 1));
      m_o  = K'(ux >> (k - (K - 1))) | K'(1);
    end else begin
      m_o = ux[K-1:0];
    end
  end

endmodule

// File: rtl/drum_pipe_mult.sv
// Three-stage DRUM approximate multiplier with valid/ready flow control and a
// tag sideband; stalls propagate combinationally back to in_ready_o.
module drum_pipe_mult
  import drum_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned K      = 4,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   in_a_i,
  input  logic [WIDTH-1:0]   in_b_i,
  input  logic [TAG_W-1:0]   in_tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] out_r_o,
  output logic [TAG_W-1:0]   out_tag_o,
  output logic               busy_o
);

  localparam int unsigned RW  = 2 * WIDTH;
  localparam int unsigned PW  = 2 * K;
  localparam int unsigned SHW = clog2(2 * WIDTH);

  logic [K-1:0]   m_a, m_b;
  logic [SHW-1:0] sh_a, sh_b;
  logic           sgn_a, sgn_b;

  logic           v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
  logic           ld1, ld2, ld3;
  logic [K-1:0]   ma_q, mb_q;
  logic [SHW-1:0] sha_q, shb_q;
  logic           sgn1_q, sgn2_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
  logic [PW-1:0]  prod_q, prod_d;
  logic [SHW-1:0] shift_q, shift_d;
  logic [RW-1:0]  mag, r_q, r_d;

  drum_operand_prep #(.WIDTH(WIDTH), .K(K), .SIGNED(SIGNED), .SHW(SHW)) u_prep_a (
    .x_i  (in_a_i),
    .m_o  (m_a),
    .sh_o (sh_a),
    .sgn_o(sgn_a)
  );

  drum_operand_prep #(.WIDTH(WIDTH), .K(K), .SIGNED(SIGNED), .SHW(SHW)) u_prep_b (
    .x_i  (in_b_i),
    .m_o  (m_b),
    .sh_o (sh_b),
    .sgn_o(sgn_b)
  );

  // A stage may load when empty or when its content moves on this edge.
  always_comb begin
    ld3     = !v3_q || out_ready_i;
    ld2     = !v2_q || ld3;
    ld1     = !v1_q || ld2;
    v1_d    = ld1 ? in_valid_i : v1_q;
    v2_d    = ld2 ? v1_q : v2_q;
    v3_d    = ld3 ? v2_q : v3_q;
    prod_d  = PW'(ma_q) * PW'(mb_q);
    shift_d = sha_q + shb_q;
    mag     = RW'(prod_q) << shift_q;
    r_d     = sgn2_q ? -mag : mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      sha_q   <= '0;
      shb_q   <= '0;
      sgn1_q  <= 1'b0;
      tag1_q  <= '0;
      prod_q  <= '0;
      shift_q <= '0;
      sgn2_q  <= 1'b0;
      tag2_q  <= '0;
      r_q     <= '0;
      tag3_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (ld1 && in_valid_i) begin
        ma_q   <= m_a;
        mb_q   <= m_b;
        sha_q  <= sh_a;
        shb_q  <= sh_b;
        sgn1_q <= sgn_a ^ sgn_b;
        tag1_q <= in_tag_i;
      end
      if (ld2 && v1_q) begin
        prod_q  <= prod_d;
        shift_q <= shift_d;
        sgn2_q  <= sgn1_q;
        tag2_q  <= tag1_q;
      end
      if (ld3 && v2_q) begin
        r_q    <= r_d;
        tag3_q <= tag2_q;
      end
    end
  end

  assign in_ready_o  = ld1;
  assign out_valid_o = v3_q;
  assign out_r_o     = r_q;
  assign out_tag_o   = tag3_q;
  assign busy_o      = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_drum_pipe_mult.sv
// Scoreboard bench for drum_pipe_mult: unsigned and signed instances, arithmetic reference model.
module tb_drum_pipe_mult;

  localparam int unsigned W  = 16;
  localparam int unsigned K  = 4;
  localparam int unsigned TW = 4;
  localparam int unsigned RW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_busy;
  logic [W-1:0]  u_a, u_b;
  logic [TW-1:0] u_tag, u_out_tag;
  logic [RW-1:0] u_r;
  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [W-1:0]  s_a, s_b;
  logic [TW-1:0] s_tag, s_out_tag;
  logic [RW-1:0] s_r;

  drum_pipe_mult #(.WIDTH(W), .K(K), .SIGNED(1'b0), .TAG_W(TW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(u_in_valid), .in_ready_o(u_in_ready),
    .in_a_i(u_a), .in_b_i(u_b), .in_tag_i(u_tag),
    .out_valid_o(u_out_valid), .out_ready_i(u_out_ready),
    .out_r_o(u_r), .out_tag_o(u_out_tag), .busy_o(u_busy)
  );

  drum_pipe_mult #(.WIDTH(W), .K(K), .SIGNED(1'b1), .TAG_W(TW)) s_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .in_a_i(s_a), .in_b_i(s_b), .in_tag_i(s_tag),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
    .out_r_o(s_r), .out_tag_o(s_out_tag), .busy_o(s_busy)
  );

  typedef struct {
    logic [RW-1:0] r;
    logic [TW-1:0] tag;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t uq[$];
  exp_t sq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   stall_left = 0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: integer DRUM arithmetic on magnitudes.
  function automatic void prep(input longint v, output longint m, output int sh);
    int n;
    n = 0;
    if (v < (longint'(1) << K)) begin
      m  = v;
      sh = 0;
    end else begin
      while ((v >> (n + 1)) != 0) n++;
      sh = n - (int'(K) - 1);
      m  = (v >> sh) | 1;
    end
  endfunction

  function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm);
    longint va, vb, ma, mb, mag;
    int     sa, sb;
    bit     neg;
    va  = longint'(a);
    vb  = longint'(b);
    neg = 1'b0;
    if (sm && a[W-1]) begin va = (longint'(1) << W) - va; neg = !neg; end
    if (sm && b[W-1]) begin vb = (longint'(1) << W) - vb; neg = !neg; end
    prep(va, ma, sa);
    prep(vb, mb, sb);
    mag = (ma * mb) << (sa + sb);
    return RW'(neg ? -mag : mag);
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return W'($urandom_range(0, 15));
      1:       return W'($urandom_range(0, 255));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic u_drive_ready();
    if (stall_left > 0) begin
      u_out_ready = 1'b0;
      stall_left--;
    end else begin
      u_out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic u_send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag,
                        input logic [RW-1:0] exp, input bit lat);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      u_drive_ready();
      u_in_valid = 1'b1;
      u_a = a;
      u_b = b;
      u_tag = tag;
      #2;
      if (u_in_ready) begin
        uq.push_back('{r: exp, tag: tag, acc: cyc, lat: lat});
        done = 1'b1;
      end
    end
    if (!done) chk("u_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic u_drain();
    for (int t = 0; t < 200 && uq.size() != 0; t++) begin
      @(negedge clk);
      u_drive_ready();
      u_in_valid = 1'b0;
      #2;
    end
    chk("u_drain", 64'(uq.size()), 64'd0);
  endtask

  task automatic s_send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag,
                        input logic [RW-1:0] exp);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      s_out_ready = 1'b1;
      s_in_valid = 1'b1;
      s_a = a;
      s_b = b;
      s_tag = tag;
      #2;
      if (s_in_ready) begin
        sq.push_back('{r: exp, tag: tag, acc: cyc, lat: 1'b0});
        done = 1'b1;
      end
    end
    if (!done) chk("s_accept_timeout", 64'd0, 64'd1);
  endtask

  // Unsigned monitor: occupancy-derived handshake, hold stability, ordered results.
  bit            u_hold = 1'b0;
  logic [RW-1:0] hold_r;
  logic [TW-1:0] hold_tag;
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      exp_t e;
      chk("u_in_ready", 64'(u_in_ready), 64'(uq.size() < 3 || u_out_ready));
      chk("u_busy", 64'(u_busy), 64'(uq.size() != 0));
      if (u_hold) begin
        chk("u_stall_valid", 64'(u_out_valid), 64'd1);
        chk("u_stall_r", 64'(u_r), 64'(hold_r));
        chk("u_stall_tag", 64'(u_out_tag), 64'(hold_tag));
      end
      if (u_out_valid && u_out_ready) begin
        if (uq.size() == 0) begin
          chk("u_unexpected_out", 64'(u_r), 64'd0);
        end else begin
          e = uq.pop_front();
          chk("u_r", 64'(u_r), 64'(e.r));
          chk("u_tag", 64'(u_out_tag), 64'(e.tag));
          if (e.lat) chk("u_latency", 64'(cyc), 64'(e.acc + 3));
        end
      end
      u_hold   = u_out_valid && !u_out_ready;
      hold_r   = u_r;
      hold_tag = u_out_tag;
    end else begin
      u_hold = 1'b0;
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst_n && s_out_valid && s_out_ready) begin
      exp_t e;
      if (sq.size() == 0) begin
        chk("s_unexpected_out", 64'(s_r), 64'd0);
      end else begin
        e = sq.pop_front();
        chk("s_r", 64'(s_r), 64'(e.r));
        chk("s_tag", 64'(s_out_tag), 64'(e.tag));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b;
    u_in_valid = 1'b0; u_a = '0; u_b = '0; u_tag = '0; u_out_ready = 1'b1;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_tag = '0; s_out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_u_valid", 64'(u_out_valid), 64'd0);
    chk("rst_u_busy", 64'(u_busy), 64'd0);
    chk("rst_u_r", 64'(u_r), 64'd0);
    chk("rst_u_tag", 64'(u_out_tag), 64'd0);
    chk("rst_s_valid", 64'(s_out_valid), 64'd0);
    chk("rst_s_r", 64'(s_r), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_u_in_ready", 64'(u_in_ready), 64'd1);

    // Directed unsigned cases, output always ready.
    u_send(16'd3, 16'd5, 4'd1, 32'd15, 1'b1);
    u_send(16'h00FF, 16'h0100, 4'd2, 32'h0001_0E00, 1'b1);
    u_send(16'hFFFF, 16'hFFFF, 4'd3, 32'hE100_0000, 1'b1);
    u_send(16'd0, 16'hFFFF, 4'd4, 32'd0, 1'b1);
    u_drain();

    // Directed and random signed cases.
    s_send(16'hFF01, 16'h0100, 4'd5, 32'hFFFE_F200);
    s_send(16'h8000, 16'h0001, 4'd6, model(16'h8000, 16'h0001, 1'b1));
    s_send(16'h0000, 16'hFFF9, 4'd7, 32'd0);
    for (int i = 0; i < 20; i++) begin
      a = rnd_op();
      b = rnd_op();
      if ($urandom_range(0, 1) != 0) a = -a;
      s_send(a, b, TW'(i), model(a, b, 1'b1));
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("s_drain", 64'(sq.size()), 64'd0);
    chk("s_busy_idle", 64'(s_busy), 64'd0);

    // Back-to-back stream under random backpressure with a 5-cycle hold.
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 6) stall_left = 5;
      a = rnd_op();
      b = rnd_op();
      u_send(a, b, TW'(i % 16), model(a, b, 1'b0), 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      a = rnd_op();
      b = rnd_op();
      u_send(a, b, TW'(i), model(a, b, 1'b0), 1'b0);
    end
    u_drain();

    // Unstalled full-throughput stream.
    rand_rdy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      a = rnd_op();
      b = rnd_op();
      u_send(a, b, TW'(i), model(a, b, 1'b0), 1'b1);
      if (i >= 3) begin
        chk("t5_out_valid", 64'(u_out_valid), 64'd1);
        chk("t5_busy", 64'(u_busy), 64'd1);
      end
    end
    u_drain();

    // Reset with three entries in flight.
    for (int i = 0; i < 3; i++) begin
      a = rnd_op();
      b = rnd_op();
      u_send(a, b, TW'(i + 8), model(a, b, 1'b0), 1'b0);
    end
    @(negedge clk);
    u_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(u_out_valid), 64'd0);
    chk("t6_rst_busy", 64'(u_busy), 64'd0);
    uq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_no_stale", 64'(u_out_valid), 64'd0);
    u_send(16'h1234, 16'h0077, 4'd9, model(16'h1234, 16'h0077, 1'b0), 1'b1);
    u_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
